// File: rtl/snn_config_loader.sv
// snn_config_loader: SPI-style serial frame receiver that emits single-cycle
// parameter register writes (single or auto-incrementing burst).
module snn_config_loader #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic [3:0] cfg_addr,
  output logic [7:0] cfg_data,
  output logic       cfg_we,
  output logic       busy,
  output logic       frame_err,
  output logic [7:0] write_count
);
  localparam logic [3:0] MAX = 4'(MAX_ADDR);
  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DRAIN} state_t;
  state_t state, nxt;
  logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, cs_sr, vld;
  logic sclk_d, cs_d, armed, burst;
  logic [3:0] cnt, hdr, addr;
  logic [7:0] shreg;
  logic s_sclk, s_mosi, s_cs, rise, cs_fall, last_bit;
  logic [3:0] hdr_addr;
  logic [7:0] byte_in;
  assign s_sclk   = sclk_sr[SYNC_STAGES-1];
  assign s_mosi   = mosi_sr[SYNC_STAGES-1];
  assign s_cs     = cs_sr[SYNC_STAGES-1];
  assign rise     = s_sclk & ~sclk_d;
  assign cs_fall  = armed & cs_d & ~s_cs;
  assign last_bit = rise && cnt == 4'd7;
  assign hdr_addr = {hdr[2:0], s_mosi};
  assign byte_in  = {shreg[6:0], s_mosi};
  // armed only after the synchronizers hold a genuine cs_n=1, so a cs_n held low
  // across reset never looks like a fresh fall
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sclk_sr <= '0;
      mosi_sr <= '0;
      cs_sr   <= '1;
      vld     <= '0;
      sclk_d  <= 1'b0;
      cs_d    <= 1'b1;
      armed   <= 1'b0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], spi_sclk};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], spi_cs_n};
      vld     <= {vld[SYNC_STAGES-2:0], 1'b1};
      sclk_d  <= s_sclk;
      cs_d    <= s_cs;
      if (vld[SYNC_STAGES-1] && s_cs) armed <= 1'b1;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = cs_fall ? HDR : IDLE;
      HDR:     nxt = s_cs ? IDLE : (rise && cnt == 4'd4) ? (hdr_addr > MAX ? DRAIN : DATA) : HDR;
      DATA:    nxt = last_bit ? WRITE : s_cs ? IDLE : DATA;
      WRITE:   nxt = s_cs ? IDLE : (burst && addr < MAX) ? DATA : DRAIN;
      DRAIN:   nxt = s_cs ? IDLE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    cfg_we = state == WRITE;
    busy   = state != IDLE;
  end
  // a completing 8th bit wins over a simultaneous cs_n rise
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt         <= '0;
      hdr         <= '0;
      addr        <= '0;
      burst       <= 1'b0;
      shreg       <= '0;
      frame_err   <= 1'b0;
      cfg_addr    <= '0;
      cfg_data    <= '0;
      write_count <= '0;
    end else begin
      case (state)
        IDLE: if (cs_fall) begin
          frame_err <= 1'b0;
          cnt       <= '0;
        end
        HDR: if (s_cs) begin
          if (cnt != 4'd0) frame_err <= 1'b1;
        end else if (rise) begin
          hdr <= hdr_addr;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd4) begin
            burst <= hdr[3];
            addr  <= hdr_addr;
            cnt   <= '0;
            if (hdr_addr > MAX) frame_err <= 1'b1;
          end
        end
        DATA: if (last_bit) begin
          cfg_addr <= addr;
          cfg_data <= byte_in;
        end else if (s_cs) begin
          if (cnt != 4'd0) frame_err <= 1'b1;
        end else if (rise) begin
          shreg <= byte_in;
          cnt   <= cnt + 4'd1;
        end
        WRITE: begin
          write_count <= write_count + 8'd1;
          cnt         <= '0;
          if (!s_cs && burst && addr < MAX) addr <= addr + 4'd1;
        end
        DRAIN: if (!s_cs && rise) frame_err <= 1'b1;
        default: ;
      endcase
    end
endmodule
